spi_cmd_master: RTL and testbench

SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

---
 rtl/spi_cmd_master.sv | 190 +++++++++++++++++++
 tb/tb_spi_cmd_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: sends one byte per chip-select assertion, MSB first,
// and captures the byte returned on MISO.
// Optional build macro SPI_CMD_MASTER_LOOPBACK_EN: RX samples o_SPI_MOSI instead of i_SPI_MISO.
`timescale 1ns/1ps
module spi_cmd_master #(
    parameter int unsigned CLKS_PER_HALF_BIT = 4,
    parameter int unsigned CS_INACTIVE_CLKS  = 8
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI,
    output logic       o_SPI_CS_n
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned EDGE_W = 5;

    localparam logic [CNT_W-1:0]  HALF_LAST     = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST      = CNT_W'(CS_INACTIVE_CLKS - 1);
    localparam logic [EDGE_W-1:0] EDGE_PRE_LAST = EDGE_W'(15);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [EDGE_W-1:0] sedge_q, sedge_d;
    logic [7:0]        tx_sh_q, tx_sh_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              rx_dv_q, rx_dv_d;
    logic              ready_q, ready_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              rx_bit_c;

    // Receive bit source: own MOSI in loopback builds, otherwise the MISO pin.
`ifdef SPI_CMD_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = i_SPI_MISO;
    assign rx_bit_c    = mosi_q;
`else
    assign rx_bit_c    = i_SPI_MISO;
`endif

    // State and output registers; reset drops CS immediately and aborts any byte.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            hcnt_q    <= '0;
            sedge_q   <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_byte_q <= '0;
            rx_dv_q   <= 1'b0;
            ready_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            sedge_q   <= sedge_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_byte_q <= rx_byte_d;
            rx_dv_q   <= rx_dv_d;
            ready_q   <= ready_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    // Next-state and next-output logic; every pin change is computed one cycle ahead.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        sedge_d   = sedge_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_byte_d = rx_byte_q;
        rx_dv_d   = 1'b0;
        ready_d   = ready_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                hcnt_d  = '0;
                sedge_d = '0;
                if (ready_q && i_TX_DV) begin
                    tx_sh_d = i_TX_Byte;
                    mosi_d  = i_TX_Byte[7];
                    cs_n_d  = 1'b0;
                    ready_d = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (hcnt_q == HALF_LAST) begin
                    // First rising SCLK edge: capture bit 7 of the reply.
                    hcnt_d  = '0;
                    sedge_d = EDGE_W'(1);
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], rx_bit_c};
                    state_d = S_SHIFT;
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (hcnt_q == HALF_LAST) begin
                    hcnt_d  = '0;
                    sedge_d = sedge_q + EDGE_W'(1);
                    sclk_d  = ~sclk_q;
                    if (!sclk_q) begin
                        rx_sh_d = {rx_sh_q[6:0], rx_bit_c};
                    end else if (sedge_q != EDGE_PRE_LAST) begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        mosi_d  = tx_sh_q[6];
                    end
                    // The 16th edge (final fall) ends the shift phase.
                    if (sedge_q == EDGE_PRE_LAST) begin
                        state_d = S_HOLD;
                    end
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (hcnt_q == '0) begin
                    rx_dv_d   = 1'b1;
                    rx_byte_d = rx_sh_q;
                end
                if (hcnt_q == HALF_LAST) begin
                    hcnt_d  = '0;
                    sedge_d = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = S_GAP;
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (hcnt_q == GAP_LAST) begin
                    hcnt_d  = '0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            default: begin
                hcnt_d  = '0;
                sedge_d = '0;
                ready_d = 1'b0;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_TX_Ready = ready_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_SPI_Clk  = sclk_q;
    assign o_SPI_MOSI = mosi_q;
    assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: mode-0 slave model plus RX/MOSI scoreboards and cycle timing checks.
`timescale 1ns/1ps
module tb_spi_cmd_master;

    localparam int H = 4;
    localparam int G = 8;
    localparam int XFER_BUDGET = 400;

    localparam int T_DV   = 2 + 16 * H;
    localparam int T_RISE = 1 + 17 * H;
    localparam int T_RDY  = 1 + 17 * H + G;

`ifdef SPI_CMD_MASTER_LOOPBACK_EN
    localparam logic [7:0] SLV_RESP = 8'h00;
`else
    localparam logic [7:0] SLV_RESP = 8'hA5;
`endif

    logic       i_Clk;
    logic       i_Rst_L;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Ready;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_SPI_Clk;
    logic       i_SPI_MISO;
    logic       o_SPI_MOSI;
    logic       o_SPI_CS_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_mosi_q[$];
    logic [7:0] rx_exp;

    spi_cmd_master #(
        .CLKS_PER_HALF_BIT(H),
        .CS_INACTIVE_CLKS (G)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_TX_DV   (i_TX_DV),
        .i_TX_Byte (i_TX_Byte),
        .o_TX_Ready(o_TX_Ready),
        .o_RX_DV   (o_RX_DV),
        .o_RX_Byte (o_RX_Byte),
        .o_SPI_Clk (o_SPI_Clk),
        .i_SPI_MISO(i_SPI_MISO),
        .o_SPI_MOSI(o_SPI_MOSI),
        .o_SPI_CS_n(o_SPI_CS_n)
    );

    // 50 MHz system clock
    initial begin
        i_Clk = 1'b0;
        forever #10 i_Clk = ~i_Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rx_expect(input logic [7:0] b);
`ifdef SPI_CMD_MASTER_LOOPBACK_EN
        return b;
`else
        return (b & 8'h00) | SLV_RESP;
`endif
    endfunction

    // Mode-0 slave: presents SLV_RESP MSB first, decodes MOSI on rising SCLK.
    initial begin : slave
        logic       pcs;
        logic       pclk;
        logic [7:0] tx_sh;
        logic [7:0] rx_sh;
        logic [7:0] e;
        int         nbits;
        i_SPI_MISO = 1'b0;
        tx_sh = '0;
        rx_sh = '0;
        nbits = 0;
        pcs   = 1'b1;
        pclk  = 1'b0;
        forever begin
            @(o_SPI_CS_n or o_SPI_Clk);
            if (pcs && !o_SPI_CS_n) begin
                tx_sh = SLV_RESP;
                i_SPI_MISO = tx_sh[7];
                nbits = 0;
                rx_sh = '0;
            end else if (!pcs && o_SPI_CS_n) begin
                i_SPI_MISO = 1'b0;
                if (exp_mosi_q.size() > 0 && nbits == 8) begin
                    e = exp_mosi_q.pop_front();
                    check("slave_mosi_byte", 32'(rx_sh), 32'(e));
                end
            end
            if (!o_SPI_CS_n && !pclk && o_SPI_Clk) begin
                rx_sh = {rx_sh[6:0], o_SPI_MOSI};
                nbits++;
            end
            if (!o_SPI_CS_n && pclk && !o_SPI_Clk) begin
                tx_sh = {tx_sh[6:0], 1'b0};
                i_SPI_MISO = tx_sh[7];
            end
            pcs  = o_SPI_CS_n;
            pclk = o_SPI_Clk;
        end
    end

    // RX scoreboard: every o_RX_DV must match the oldest outstanding expectation.
    always @(negedge i_Clk) begin
        if (o_RX_DV === 1'b1) begin
            if (exp_rx_q.size() == 0) begin
                check("rx_dv_spurious", 32'd1, 32'd0);
            end else begin
                rx_exp = exp_rx_q.pop_front();
                check("rx_byte", 32'(o_RX_Byte), 32'(rx_exp));
            end
        end
    end

    // One full byte; cycle 0 is the DV cycle. Optional stray DV (8'h3C) at cycle ig_k.
    task automatic xfer(input logic [7:0] b, input int ig_k);
        int   cs_first;
        int   cs_rise;
        int   rdy_k;
        int   dv_k;
        int   dv_n;
        int   falls;
        int   rises;
        int   viol;
        logic pcs;
        logic pclk;
        cs_first = -1;
        cs_rise  = -1;
        rdy_k    = -1;
        dv_k     = -1;
        dv_n     = 0;
        falls    = 0;
        rises    = 0;
        viol     = 0;
        check("xfer_ready_in", 32'(o_TX_Ready), 32'd1);
        pcs  = o_SPI_CS_n;
        pclk = o_SPI_Clk;
        i_TX_DV   = 1'b1;
        i_TX_Byte = b;
        exp_rx_q.push_back(rx_expect(b));
        exp_mosi_q.push_back(b);
        for (int k = 1; k <= XFER_BUDGET; k++) begin
            @(negedge i_Clk);
            if (k == 1) i_TX_DV = 1'b0;
            if (ig_k > 0 && k == ig_k) begin
                i_TX_DV   = 1'b1;
                i_TX_Byte = 8'h3C;
            end
            if (ig_k > 0 && k == ig_k + 1) i_TX_DV = 1'b0;
            if (k == 1) check("setup_mosi_bit7", 32'(o_SPI_MOSI), 32'(b[7]));
            if (pcs && !o_SPI_CS_n) begin
                falls++;
                if (cs_first < 0) cs_first = k;
            end
            if (!pcs && o_SPI_CS_n) cs_rise = k;
            if (!pclk && o_SPI_Clk) rises++;
            if (o_SPI_CS_n && (o_SPI_MOSI || o_SPI_Clk)) viol++;
            if (o_RX_DV) begin
                dv_n++;
                dv_k = k;
            end
            pcs  = o_SPI_CS_n;
            pclk = o_SPI_Clk;
            if (o_TX_Ready) begin
                rdy_k = k;
                break;
            end
        end
        check("cs_fall_cycle", 32'(cs_first), 32'd1);
        check("cs_fall_count", 32'(falls), 32'd1);
        check("sclk_rises", 32'(rises), 32'd8);
        check("rx_dv_cycle", 32'(dv_k), 32'(T_DV));
        check("rx_dv_count", 32'(dv_n), 32'd1);
        check("cs_rise_cycle", 32'(cs_rise), 32'(T_RISE));
        check("ready_cycle", 32'(rdy_k), 32'(T_RDY));
        check("cs_high_gap_ok", 32'(((rdy_k - cs_rise + 1) >= G) ? 1 : 0), 32'd1);
        check("idle_pins_quiet", 32'(viol), 32'd0);
    endtask

    // Start a byte and pull reset at cycle at_k; CS must drop out at once.
    task automatic abort_xfer(input logic [7:0] b, input int at_k);
        i_TX_DV   = 1'b1;
        i_TX_Byte = b;
        for (int k = 1; k <= at_k; k++) begin
            @(negedge i_Clk);
            if (k == 1) i_TX_DV = 1'b0;
        end
        check("abort_cs_low_before", 32'(o_SPI_CS_n), 32'd0);
        i_Rst_L = 1'b0;
        #1;
        check("abort_cs_n", 32'(o_SPI_CS_n), 32'd1);
        check("abort_sclk", 32'(o_SPI_Clk), 32'd0);
        check("abort_rx_dv", 32'(o_RX_DV), 32'd0);
        check("abort_ready", 32'(o_TX_Ready), 32'd0);
        repeat (3) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        check("ready_after_abort", 32'(o_TX_Ready), 32'd1);
    endtask

    initial begin
        i_Rst_L   = 1'b0;
        i_TX_DV   = 1'b0;
        i_TX_Byte = 8'h00;
        repeat (3) @(negedge i_Clk);
        check("rst_cs_n", 32'(o_SPI_CS_n), 32'd1);
        check("rst_sclk", 32'(o_SPI_Clk), 32'd0);
        check("rst_mosi", 32'(o_SPI_MOSI), 32'd0);
        check("rst_rx_dv", 32'(o_RX_DV), 32'd0);
        check("rst_rx_byte", 32'(o_RX_Byte), 32'h00);
        check("rst_ready", 32'(o_TX_Ready), 32'd0);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        check("ready_after_rst", 32'(o_TX_Ready), 32'd1);

        xfer(8'h01, 0);
        repeat (5) @(negedge i_Clk);

        xfer(8'hFF, 0);
        xfer(8'h00, 0);
        repeat (3) @(negedge i_Clk);

        xfer(8'h96, 20);
        repeat (10) @(negedge i_Clk);
        check("stray_dv_cs_idle", 32'(o_SPI_CS_n), 32'd1);
        check("stray_dv_ready", 32'(o_TX_Ready), 32'd1);

        abort_xfer(8'hC3, 30);
        xfer(8'h5A, 0);
        check("rx_byte_held", 32'(o_RX_Byte), 32'(rx_expect(8'h5A)));
        repeat (5) @(negedge i_Clk);

        check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
        check("mosi_queue_drained", 32'(exp_mosi_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_checks);
        $fatal(1, "time limit reached");
    end

endmodule
